rs_checker: RTL and testbench

Synthesizable, parametrised run-time protocol checker for the reservation station. It sits beside the RS and taps the same dispatch, CDB, issue and branch-resolve signals. It keeps its own shadow state, namely the previous-cycle branch resolve and per-entry pending wake-ups, so it can check free-slot accounting, squash, b_mask clearing and CDB wake-up every cycle. It latches the first violation plus a saturating error count, so the RS can be checked on FPGA and in gate-level runs as well as in RTL simulation.

---
 rtl/rs_checker.sv | 203 ++++++++++++++++++++
 tb/tb_rs_checker.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_checker.sv
// Run-time protocol checker for the reservation station: it shadows branch resolve and CDB wake-ups and latches the first violation.
// Define RS_CHK_WAKE_EN to compile in the pending wake-up tracking and the WAKE1/WAKE2 checks (codes 5/6).
module rs_checker #(
    parameter int RS_SZ        = 16,
    parameter int N            = 3,
    parameter int B_MASK_WIDTH = 4,
    parameter int PREG_BITS    = 6,
    parameter int ERR_CNT_BITS = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          chk_en,
    input  logic                          err_clear,
    input  logic [RS_SZ-1:0]              rs_valid,
    input  logic [RS_SZ-1:0]              rs_valid_next,
    input  logic [RS_SZ-1:0]              rs_issuing,
    input  logic [RS_SZ*PREG_BITS-1:0]    rs_src1_tag,
    input  logic [RS_SZ*PREG_BITS-1:0]    rs_src2_tag,
    input  logic [RS_SZ-1:0]              rs_src1_ready,
    input  logic [RS_SZ-1:0]              rs_src2_ready,
    input  logic [RS_SZ*B_MASK_WIDTH-1:0] rs_b_mask,
    input  logic [$clog2(N+1)-1:0]        rs_spots,
    input  logic [$clog2(N+1)-1:0]        num_dispatched,
    input  logic [N-1:0]                  cdb_valid,
    input  logic [N*PREG_BITS-1:0]        cdb_tags,
    input  logic [B_MASK_WIDTH-1:0]       b_mm_resolve,
    input  logic                          b_mm_mispred,
    output logic                          err_valid,
    output logic [2:0]                    err_code,
    output logic [$clog2(RS_SZ)-1:0]      err_entry,
    output logic [ERR_CNT_BITS-1:0]       err_count
);

    localparam int IDX_W = $clog2(RS_SZ);

    typedef enum logic [2:0] {
        CODE_NONE     = 3'd0,
        CODE_SPOTS    = 3'd1,
        CODE_DISP_OVF = 3'd2,
        CODE_SQUASH   = 3'd3,
        CODE_RESOLVE  = 3'd4,
        CODE_WAKE1    = 3'd5,
        CODE_WAKE2    = 3'd6
    } err_code_e;

    // Lowest set bit wins so that entry priority is deterministic.
    function automatic logic [IDX_W-1:0] first_set(input logic [RS_SZ-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = RS_SZ - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    logic [B_MASK_WIDTH-1:0] resolve_prev;
    logic                    spots_fail;
    logic                    disp_fail;
    logic [RS_SZ-1:0]        squash_vec;
    logic [RS_SZ-1:0]        resolve_vec;
    logic [RS_SZ-1:0]        wake1_vec;
    logic [RS_SZ-1:0]        wake2_vec;
    err_code_e               cur_code;
    logic [IDX_W-1:0]        cur_entry;
    logic                    violation;
    err_code_e               code_q;

    // Free-slot and dispatch-width accounting.
    always_comb begin
        int pop_cnt;
        int free_cnt;
        int exp_spots;
        // NOTE: every combinational output gets a default first so no latch can be inferred.
        pop_cnt = 0;
        for (int i = 0; i < RS_SZ; i++) begin
            pop_cnt = pop_cnt + int'(rs_valid[i]);
        end
        free_cnt   = RS_SZ - pop_cnt;
        exp_spots  = (free_cnt > N) ? N : free_cnt;
        spots_fail = (int'(rs_spots) != exp_spots);
        disp_fail  = (int'(num_dispatched) > int'(rs_spots)) || (int'(num_dispatched) > N);
    end

    always_comb begin
        logic [B_MASK_WIDTH-1:0] mask;
        squash_vec  = '0;
        resolve_vec = '0;
        for (int i = 0; i < RS_SZ; i++) begin
            mask           = rs_b_mask[i*B_MASK_WIDTH +: B_MASK_WIDTH];
            squash_vec[i]  = b_mm_mispred && rs_valid[i] && (|(mask & b_mm_resolve)) && rs_valid_next[i];
            resolve_vec[i] = rs_valid[i] && (|(mask & resolve_prev));
        end
    end

    // A mispredicted resolve squashes its dependants instead of clearing their mask bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resolve_prev <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            resolve_prev <= b_mm_mispred ? '0 : b_mm_resolve;
        end
    end

`ifdef RS_CHK_WAKE_EN
    logic [RS_SZ-1:0] match1;
    logic [RS_SZ-1:0] match2;
    logic [RS_SZ-1:0] pend1;
    logic [RS_SZ-1:0] pend2;
    logic [RS_SZ-1:0] arm;

    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int i = 0; i < RS_SZ; i++) begin
            for (int j = 0; j < N; j++) begin
                if (cdb_valid[j] &&
                    cdb_tags[j*PREG_BITS +: PREG_BITS] == rs_src1_tag[i*PREG_BITS +: PREG_BITS])
                    match1[i] = 1'b1;
                if (cdb_valid[j] &&
                    cdb_tags[j*PREG_BITS +: PREG_BITS] == rs_src2_tag[i*PREG_BITS +: PREG_BITS])
                    match2[i] = 1'b1;
            end
        end
    end

    // Entries that issue or free this cycle never owe a wake-up next cycle.
    assign arm = rs_valid & rs_valid_next & ~rs_issuing;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend1 <= '0;
            pend2 <= '0;
        end else begin
            pend1 <= arm & match1;
            pend2 <= arm & match2;
        end
    end

    assign wake1_vec = pend1 & rs_valid & ~rs_src1_ready;
    assign wake2_vec = pend2 & rs_valid & ~rs_src2_ready;
`else
    logic unused_wake;
    assign unused_wake = ^{rs_issuing, rs_src1_tag, rs_src2_tag, rs_src1_ready,
                           rs_src2_ready, cdb_valid, cdb_tags};
    assign wake1_vec   = '0;
    assign wake2_vec   = '0;
`endif

    // Lowest code first, then lowest entry index.
    always_comb begin
        cur_code  = CODE_NONE;
        cur_entry = '0;
        if (spots_fail) begin
            cur_code = CODE_SPOTS;
        end else if (disp_fail) begin
            cur_code = CODE_DISP_OVF;
        end else if (|squash_vec) begin
            cur_code  = CODE_SQUASH;
            cur_entry = first_set(squash_vec);
        end else if (|resolve_vec) begin
            cur_code  = CODE_RESOLVE;
            cur_entry = first_set(resolve_vec);
        end else if (|wake1_vec) begin
            cur_code  = CODE_WAKE1;
            cur_entry = first_set(wake1_vec);
        end else if (|wake2_vec) begin
            cur_code  = CODE_WAKE2;
            cur_entry = first_set(wake2_vec);
        end
    end

    assign violation = chk_en && (cur_code != CODE_NONE);

    // A violation in the clearing cycle restarts the record rather than being lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid <= 1'b0;
            code_q    <= CODE_NONE;
            err_entry <= '0;
            err_count <= '0;
        end else if (violation) begin
            err_valid <= 1'b1;
            if (err_clear || !err_valid) begin
                code_q    <= cur_code;
                err_entry <= cur_entry;
            end
            if (err_clear) begin
                err_count <= ERR_CNT_BITS'(1);
            end else if (err_count != '1) begin
                err_count <= err_count + ERR_CNT_BITS'(1);
            end
        end else if (err_clear) begin
            err_valid <= 1'b0;
            code_q    <= CODE_NONE;
            err_entry <= '0;
            err_count <= '0;
        end
    end

    assign err_code = code_q;

endmodule

// File: tb/tb_rs_checker.sv
// Scoreboard bench for rs_checker: stimulus queues expected error outputs, a monitor compares them after each edge.
// Expected WAKE1/WAKE2 results follow the RS_CHK_WAKE_EN build option.
module tb_rs_checker;

    localparam int RS_SZ = 16;
    localparam int N     = 3;
    localparam int BMW   = 4;
    localparam int PB    = 6;
    localparam int ECB   = 16;
`ifdef RS_CHK_WAKE_EN
    localparam bit WK = 1'b1;
`else
    localparam bit WK = 1'b0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic                   chk_en;
    logic                   err_clear;
    logic [RS_SZ-1:0]       rs_valid;
    logic [RS_SZ-1:0]       rs_valid_next;
    logic [RS_SZ-1:0]       rs_issuing;
    logic [RS_SZ*PB-1:0]    rs_src1_tag;
    logic [RS_SZ*PB-1:0]    rs_src2_tag;
    logic [RS_SZ-1:0]       rs_src1_ready;
    logic [RS_SZ-1:0]       rs_src2_ready;
    logic [RS_SZ*BMW-1:0]   rs_b_mask;
    logic [1:0]             rs_spots;
    logic [1:0]             num_dispatched;
    logic [N-1:0]           cdb_valid;
    logic [N*PB-1:0]        cdb_tags;
    logic [BMW-1:0]         b_mm_resolve;
    logic                   b_mm_mispred;
    logic                   err_valid;
    logic [2:0]             err_code;
    logic [3:0]             err_entry;
    logic [ECB-1:0]         err_count;

    rs_checker #(
        .RS_SZ(RS_SZ), .N(N), .B_MASK_WIDTH(BMW), .PREG_BITS(PB), .ERR_CNT_BITS(ECB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .err_clear(err_clear),
        .rs_valid(rs_valid), .rs_valid_next(rs_valid_next), .rs_issuing(rs_issuing),
        .rs_src1_tag(rs_src1_tag), .rs_src2_tag(rs_src2_tag),
        .rs_src1_ready(rs_src1_ready), .rs_src2_ready(rs_src2_ready),
        .rs_b_mask(rs_b_mask), .rs_spots(rs_spots), .num_dispatched(num_dispatched),
        .cdb_valid(cdb_valid), .cdb_tags(cdb_tags),
        .b_mm_resolve(b_mm_resolve), .b_mm_mispred(b_mm_mispred),
        .err_valid(err_valid), .err_code(err_code), .err_entry(err_entry), .err_count(err_count)
    );

    typedef struct {
        int    tag;
        string name;
        int    v;
        int    code;
        int    entry;
        int    count;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expectation applies to the outputs after the next rising edge.
    task automatic push_exp(input string name, input int v, input int code, input int entry,
                            input int count);
        exp_t e;
        e.tag = cyc + 1; e.name = name; e.v = v; e.code = code; e.entry = entry; e.count = count;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        #1;
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            e = sb.pop_front();
            check({e.name, "_slot"}, 32'(e.tag), 32'(cyc));
            check({e.name, "_valid"}, 32'(err_valid), 32'(e.v));
            check({e.name, "_code"}, 32'(err_code), 32'(e.code));
            check({e.name, "_entry"}, 32'(err_entry), 32'(e.entry));
            check({e.name, "_count"}, 32'(err_count), 32'(e.count));
        end
    end

    task automatic set_base();
        chk_en         = 1'b1;
        err_clear      = 1'b0;
        rs_valid       = 16'h3FFF;
        rs_valid_next  = 16'h3FFF;
        rs_issuing     = '0;
        rs_src1_tag    = '0;
        rs_src2_tag    = '0;
        rs_src1_ready  = '1;
        rs_src2_ready  = '1;
        rs_b_mask      = '0;
        rs_spots       = 2'd2;
        num_dispatched = 2'd2;
        cdb_valid      = '0;
        cdb_tags       = '0;
        b_mm_resolve   = '0;
        b_mm_mispred   = 1'b0;
    endtask

    task automatic set_mask(input int i, input logic [BMW-1:0] m);
        rs_b_mask[i*BMW +: BMW] = m;
    endtask

    task automatic set_cdb(input int j, input logic [PB-1:0] t);
        cdb_valid[j]        = 1'b1;
        cdb_tags[j*PB +: PB] = t;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        set_base();
        #1;
        check("reset_valid", 32'(err_valid), 0);
        check("reset_code", 32'(err_code), 0);
        check("reset_entry", 32'(err_entry), 0);
        check("reset_count", 32'(err_count), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        push_exp("release", 0, 0, 0, 0);

        for (int i = 0; i < 50; i++) begin
            tick(); push_exp("quiet", 0, 0, 0, 0);
        end

        tick(); rs_valid = '1; rs_valid_next = '1; rs_spots = 2'd0; num_dispatched = 2'd0;
        push_exp("full_rs", 0, 0, 0, 0);
        tick(); rs_valid = '0; rs_valid_next = '0; rs_spots = 2'd3; num_dispatched = 2'd3;
        push_exp("empty_rs", 0, 0, 0, 0);

        tick(); set_base(); rs_spots = 2'd3;
        push_exp("spots", 1, 1, 0, 1);
        for (int k = 2; k <= 5; k++) begin
            tick(); push_exp("spots_hold", 1, 1, 0, k);
        end
        tick(); set_base(); err_clear = 1'b1;
        push_exp("clear", 0, 0, 0, 0);

        tick(); set_base(); num_dispatched = 2'd3;
        push_exp("disp_ovf", 1, 2, 0, 1);
        tick(); rs_spots = 2'd3;
        push_exp("first_kept", 1, 2, 0, 2);
        tick(); set_base(); err_clear = 1'b1;
        push_exp("clear2", 0, 0, 0, 0);

        tick(); set_base(); set_mask(5, 4'b0010); b_mm_resolve = 4'b0010; b_mm_mispred = 1'b1;
        push_exp("squash", 1, 3, 5, 1);
        tick(); set_base(); set_mask(5, 4'b0010);
        push_exp("mispred_forced", 1, 3, 5, 1);

        tick(); set_base(); set_mask(2, 4'b0100); set_mask(9, 4'b0100); b_mm_resolve = 4'b0100;
        push_exp("resolve_setup", 1, 3, 5, 1);
        tick(); b_mm_resolve = '0; err_clear = 1'b1;
        push_exp("resolve_clear", 1, 4, 2, 1);
        tick(); set_base(); err_clear = 1'b1;
        push_exp("clear3", 0, 0, 0, 0);

        tick(); set_base(); set_mask(2, 4'b0100); set_mask(9, 4'b0100);
        b_mm_resolve = 4'b0100; b_mm_mispred = 1'b1; rs_valid_next[2] = 1'b0; rs_valid_next[9] = 1'b0;
        push_exp("squash_ok", 0, 0, 0, 0);
        tick(); b_mm_resolve = '0; b_mm_mispred = 1'b0; rs_valid_next = 16'h3FFF;
        push_exp("squash_no_resolve", 0, 0, 0, 0);

        tick(); set_base(); chk_en = 1'b0; rs_spots = 2'd3; set_mask(2, 4'b0100); b_mm_resolve = 4'b0100;
        push_exp("chk_off", 0, 0, 0, 0);
        tick(); set_base(); set_mask(2, 4'b0100);
        push_exp("resolve_tracked", 1, 4, 2, 1);
        tick(); set_base(); err_clear = 1'b1;
        push_exp("clear4", 0, 0, 0, 0);

        tick(); set_base(); rs_src1_tag[7*PB +: PB] = 6'd12; set_cdb(1, 6'd12);
        push_exp("wake1_arm", 0, 0, 0, 0);
        tick(); set_base(); rs_src1_tag[7*PB +: PB] = 6'd12; rs_src1_ready[7] = 1'b0;
        push_exp("wake1", WK ? 1 : 0, WK ? 5 : 0, WK ? 7 : 0, WK ? 1 : 0);
        tick(); set_base(); err_clear = 1'b1;
        push_exp("clear5", 0, 0, 0, 0);
        tick(); set_base(); rs_src1_tag[7*PB +: PB] = 6'd12; set_cdb(1, 6'd12); rs_issuing[7] = 1'b1;
        push_exp("wake1_issue_arm", 0, 0, 0, 0);
        tick(); set_base(); rs_src1_ready[7] = 1'b0;
        push_exp("wake1_issue", 0, 0, 0, 0);
        tick(); set_base(); rs_src2_tag[3*PB +: PB] = 6'd33; set_cdb(2, 6'd33);
        push_exp("wake2_arm", 0, 0, 0, 0);
        tick(); set_base(); rs_src2_ready[3] = 1'b0;
        push_exp("wake2", WK ? 1 : 0, WK ? 6 : 0, WK ? 3 : 0, WK ? 1 : 0);
        tick(); set_base(); err_clear = 1'b1;
        push_exp("clear6", 0, 0, 0, 0);
        tick(); set_base(); rs_src1_tag[7*PB +: PB] = 6'd12; set_cdb(1, 6'd12); rs_valid_next[7] = 1'b0;
        push_exp("wake1_free_arm", 0, 0, 0, 0);
        tick(); set_base(); rs_src1_ready[7] = 1'b0;
        push_exp("wake1_free", 0, 0, 0, 0);

        tick(); set_base(); rs_spots = 2'd3;
        push_exp("pre_reset1", 1, 1, 0, 1);
        tick(); push_exp("pre_reset2", 1, 1, 0, 2);
        tick(); push_exp("pre_reset3", 1, 1, 0, 3);
        tick(); rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(err_valid), 0);
        check("async_reset_code", 32'(err_code), 0);
        check("async_reset_entry", 32'(err_entry), 0);
        check("async_reset_count", 32'(err_count), 0);
        push_exp("in_reset", 0, 0, 0, 0);
        tick(); rst_n = 1'b1; chk_en = 1'b0;
        push_exp("chk_off_after_reset", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); push_exp("chk_off_hold", 0, 0, 0, 0);
        end

        tick(); rst_n = 1'b0; set_base(); set_mask(2, 4'b0100); b_mm_resolve = 4'b0100;
        push_exp("reset_resolve", 0, 0, 0, 0);
        tick(); rst_n = 1'b1;
        push_exp("first_after_release", 0, 0, 0, 0);
        tick(); b_mm_resolve = '0;
        push_exp("resolve_after_release", 1, 4, 2, 1);

        tick();
        for (int i = 0; i < 5 && sb.size() > 0; i++) tick();
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
